spike_readout_drain: RTL and testbench

- Consumer at the read end of the output spike FIFO (4-bit spike_id entries written by the LIF stage).
- Pops one entry per cycle while the FIFO is non-empty and keeps a saturating per-class spike count.
- After the producer signals frame end, drains any remaining entries, then runs a sequential argmax over the class counters.
- Exposes the winning class, per-class counts and a done pulse to the CPU register block.

---
 rtl/snn_pkg.sv | 16 +
 rtl/spike_readout_drain.sv | 158 +++++++++++++++
 tb/tb_spike_readout_drain.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN readout path.
// Defaults here size the spike FIFO, readout counters and drain FSM.
package snn_pkg;

  localparam int SPIKE_ID_W    = 4;
  localparam int NUM_CLASSES   = 10;
  localparam int READOUT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    FLUSH  = 2'd2,
    ARGMAX = 2'd3
  } drain_state_e;

endpackage

// File: rtl/spike_readout_drain.sv
// Drains the output spike FIFO into saturating per-class counters, then
// runs a one-class-per-cycle argmax and reports the winning class.
module spike_readout_drain #(
  parameter int ID_W        = snn_pkg::SPIKE_ID_W,
  parameter int NUM_CLASSES = snn_pkg::NUM_CLASSES,
  parameter int CNT_W       = snn_pkg::READOUT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             frame_done,
  input  logic             fifo_empty,
  input  logic [ID_W-1:0]  fifo_rd_data,
  output logic             fifo_pop,
  input  logic [ID_W-1:0]  cnt_rd_idx,
  output logic [CNT_W-1:0] cnt_rd_data,
  output logic [ID_W-1:0]  winner,
  output logic             winner_valid,
  output logic             busy,
  output logic             done,
  output logic             id_err,
  output logic             sat
);
  import snn_pkg::*;

  localparam logic [ID_W:0]    NC   = (ID_W+1)'(NUM_CLASSES);
  localparam logic [ID_W-1:0]  LAST = ID_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  drain_state_e state_q, state_d;
  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  idx_q, idx_d;
  logic [ID_W-1:0]  best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [ID_W-1:0]  winner_q, winner_d;
  logic             winner_valid_q, winner_valid_d;
  logic             id_err_q, id_err_d;
  logic             sat_q, sat_d;

  logic             id_ok;
  logic             last_step;
  logic             cur_gt;
  logic [CNT_W-1:0] cur_cnt;

  // Counter currently visited by the argmax iterator.
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (idx_q == ID_W'(i)) cur_cnt = cnt_q[i];
  end

  always_comb begin
    cnt_rd_data = '0;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (cnt_rd_idx == ID_W'(i)) cnt_rd_data = cnt_q[i];
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    best_idx_d     = best_idx_q;
    best_cnt_d     = best_cnt_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    id_err_d       = id_err_q;
    sat_d          = sat_q;

    fifo_pop  = ((state_q == DRAIN) || (state_q == FLUSH)) && !fifo_empty;
    id_ok     = {1'b0, fifo_rd_data} < NC;
    last_step = (state_q == ARGMAX) && (idx_q == LAST);
    cur_gt    = cur_cnt > best_cnt_q;
    done      = last_step && !start;

    if (start) begin
      // Restart wins over everything, including a pop in the same cycle.
      cnt_d          = '0;
      id_err_d       = 1'b0;
      sat_d          = 1'b0;
      winner_valid_d = 1'b0;
      state_d        = DRAIN;
    end else begin
      if (fifo_pop) begin
        if (id_ok) begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            if (fifo_rd_data == ID_W'(i)) begin
              if (cnt_q[i] == CMAX) sat_d = 1'b1;
              else                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end else begin
          id_err_d = 1'b1;
        end
      end

      case (state_q)
        IDLE: ;
        DRAIN: begin
          if (frame_done) state_d = FLUSH;
        end
        FLUSH: begin
          if (fifo_empty) begin
            state_d    = ARGMAX;
            idx_d      = '0;
            best_idx_d = '0;
            best_cnt_d = cnt_q[0];
          end
        end
        ARGMAX: begin
          // Strict greater keeps the lowest index on ties.
          if (cur_gt) begin
            best_cnt_d = cur_cnt;
            best_idx_d = idx_q;
          end
          if (last_step) begin
            winner_d       = cur_gt ? idx_q : best_idx_q;
            winner_valid_d = 1'b1;
            state_d        = IDLE;
          end else begin
            idx_d = idx_q + ID_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      best_idx_q     <= '0;
      best_cnt_q     <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      id_err_q       <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      best_idx_q     <= best_idx_d;
      best_cnt_q     <= best_cnt_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      id_err_q       <= id_err_d;
      sat_q          <= sat_d;
    end
  end

  assign winner       = winner_q;
  assign winner_valid = winner_valid_q;
  assign busy         = (state_q != IDLE);
  assign id_err       = id_err_q;
  assign sat          = sat_q;

endmodule

// File: tb/tb_spike_readout_drain.sv
// Directed bench for spike_readout_drain with a behavioural fall-through FIFO.
module tb_spike_readout_drain;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       frame_done = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_rd_data = 4'h0;
  logic       fifo_pop;
  logic [3:0] cnt_rd_idx = 4'h0;
  logic [7:0] cnt_rd_data;
  logic [3:0] winner;
  logic       winner_valid;
  logic       busy;
  logic       done;
  logic       id_err;
  logic       sat;

  logic [3:0] q[$];
  int n_chk = 0;
  int n_fail = 0;
  int npop = 0;
  int ndone = 0;
  int pop_empty = 0;

  spike_readout_drain dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_done(frame_done),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_pop(fifo_pop),
    .cnt_rd_idx(cnt_rd_idx), .cnt_rd_data(cnt_rd_data), .winner(winner),
    .winner_valid(winner_valid), .busy(busy), .done(done), .id_err(id_err), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty   = (q.size() == 0);
    fifo_rd_data = fifo_empty ? 4'h0 : q[0];
  endtask

  task automatic push(input logic [3:0] id);
    q.push_back(id);
    refresh();
  endtask

  // One clock: sample combinational outputs mid-cycle, then apply the FIFO pop.
  task automatic step();
    logic p;
    @(negedge clk);
    p = fifo_pop;
    if (p) npop++;
    if (p && fifo_empty) pop_empty++;
    if (done) ndone++;
    @(posedge clk);
    #1;
    if (p && q.size() > 0) void'(q.pop_front());
    start = 1'b0;
    frame_done = 1'b0;
    refresh();
  endtask

  task automatic wait_done(input int limit, output int n);
    int d0;
    bit seen;
    d0 = ndone;
    seen = 0;
    n = 0;
    while (!seen && n < limit) begin
      step();
      n++;
      if (ndone != d0) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    step();
    step();
    chk("done_one_cycle", 32'(ndone - d0), 32'd1);
  endtask

  task automatic chk_cnt(input logic [3:0] idx, input logic [7:0] exp);
    cnt_rd_idx = idx;
    #1;
    chk($sformatf("cnt[%0d]", idx), 32'(cnt_rd_data), 32'(exp));
  endtask

  initial begin
    int n;
    refresh();
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_wvalid", 32'(winner_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_id_err", 32'(id_err), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_pop", 32'(fifo_pop), 0);
    chk_cnt(4'd3, 8'd0);
    rst_n = 1'b1;
    step();

    // Basic frame: 3,3,7,3
    start = 1'b1;
    step();
    chk("t1_busy", 32'(busy), 1);
    npop = 0;
    push(4'd3); push(4'd3); push(4'd7); push(4'd3);
    for (int i = 0; i < 4; i++) step();
    frame_done = 1'b1;
    step();
    wait_done(50, n);
    chk("t1_latency", 32'(n), 32'd11);
    chk("t1_pops", 32'(npop), 32'd4);
    chk("t1_winner", 32'(winner), 32'd3);
    chk("t1_wvalid", 32'(winner_valid), 1);
    chk("t1_idle", 32'(busy), 0);
    chk_cnt(4'd3, 8'd3);
    chk_cnt(4'd7, 8'd1);
    chk_cnt(4'd12, 8'd0);

    // Tie between 5 and 2 resolves to the lower index
    start = 1'b1;
    step();
    chk("t2_wvalid_clr", 32'(winner_valid), 0);
    chk_cnt(4'd3, 8'd0);
    push(4'd5); push(4'd2); push(4'd5); push(4'd2);
    frame_done = 1'b1;
    step();
    wait_done(50, n);
    chk("t2_winner", 32'(winner), 32'd2);
    chk_cnt(4'd5, 8'd2);

    // frame_done with 5 entries still queued
    start = 1'b1;
    step();
    npop = 0;
    push(4'd6); push(4'd6); push(4'd1); push(4'd6); push(4'd9);
    frame_done = 1'b1;
    step();
    wait_done(50, n);
    chk("t3_latency", 32'(n), 32'd15);
    chk("t3_pops", 32'(npop), 32'd5);
    chk("t3_winner", 32'(winner), 32'd6);
    chk_cnt(4'd6, 8'd3);
    chk_cnt(4'd1, 8'd1);
    chk_cnt(4'd9, 8'd1);

    // Out-of-range ID
    start = 1'b1;
    step();
    push(4'd12); push(4'd4);
    frame_done = 1'b1;
    step();
    wait_done(50, n);
    chk("t4_id_err", 32'(id_err), 1);
    for (int i = 0; i < 10; i++) chk_cnt(4'(i), (i == 4) ? 8'd1 : 8'd0);
    chk("t4_winner", 32'(winner), 32'd4);

    // Saturation on ID 1
    start = 1'b1;
    step();
    chk("t5_id_err_clr", 32'(id_err), 0);
    for (int i = 0; i < 300; i++) q.push_back(4'd1);
    refresh();
    frame_done = 1'b1;
    step();
    wait_done(400, n);
    chk("t5_sat", 32'(sat), 1);
    chk("t5_winner", 32'(winner), 32'd1);
    chk_cnt(4'd1, 8'd255);

    // Restart mid-DRAIN; the pop coinciding with start is dropped
    start = 1'b1;
    step();
    push(4'd2); push(4'd2); push(4'd2);
    for (int i = 0; i < 3; i++) step();
    chk_cnt(4'd2, 8'd3);
    push(4'd9);
    start = 1'b1;
    step();
    chk("t6_sat_clr", 32'(sat), 0);
    push(4'd4);
    step();
    frame_done = 1'b1;
    step();
    wait_done(50, n);
    chk("t6_winner", 32'(winner), 32'd4);
    chk_cnt(4'd4, 8'd1);
    chk_cnt(4'd2, 8'd0);
    chk_cnt(4'd9, 8'd0);

    // Reset in the middle of ARGMAX
    start = 1'b1;
    step();
    push(4'd5);
    step();
    frame_done = 1'b1;
    step();
    step();
    step(); step(); step();
    chk("t7_busy_pre", 32'(busy), 1);
    n = ndone;
    rst_n = 1'b0;
    q.delete();
    refresh();
    #1;
    chk("t7_busy", 32'(busy), 0);
    chk("t7_done", 32'(done), 0);
    chk("t7_winner", 32'(winner), 0);
    chk("t7_wvalid", 32'(winner_valid), 0);
    chk("t7_pop", 32'(fifo_pop), 0);
    chk_cnt(4'd5, 8'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("t7_no_done", 32'(ndone - n), 0);
    chk("t7_idle", 32'(busy), 0);
    chk("pop_while_empty", 32'(pop_empty), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
